// File: rtl/sram_reg_staged_access_if.sv
// Bus bundles for the staged SRAM register bridge: the register-decode side and
// the SRAM-arbiter requester side.
interface sram_reg_bus_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              reg_req;
    logic              reg_rd_wr_L;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              reg_ack;
    logic [DATA_W-1:0] reg_rd_data;
    logic              timeout;

    modport master (
        output reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        input  reg_ack, reg_rd_data, timeout
    );
    modport slave (
        input  reg_req, reg_rd_wr_L, reg_addr, reg_wr_data,
        output reg_ack, reg_rd_data, timeout
    );
endinterface

interface sram_arb_port_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 72
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_data, rd_vld, wr_ack
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_data, rd_vld, wr_ack
    );
endinterface

// File: rtl/sram_reg_staged_access.sv
// Register-word window onto wide SRAM words: staged whole-word commits, a snapshot
// latch serving sibling-word reads, and timeout-bounded SRAM handshakes.
module sram_reg_staged_access #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int TIMEOUT         = 1024
) (
    input  logic             clk,
    input  logic             reset,
    sram_reg_bus_if.slave    reg_bus,
    sram_arb_port_if.master  sram_bus
);
    localparam int N              = (SRAM_DATA_WIDTH + REG_DATA_WIDTH - 1) / REG_DATA_WIDTH;
    localparam int WSEL_W         = (N > 1) ? $clog2(N) : 1;
    localparam int WORDS          = 2 ** WSEL_W;
    localparam int REG_ADDR_WIDTH = SRAM_ADDR_WIDTH + WSEL_W;
    localparam int STG_N          = (N > 1) ? N - 1 : 1;
    localparam int PAD_W          = WORDS * REG_DATA_WIDTH;
    localparam int TMO_W          = $clog2(TIMEOUT + 1);

    localparam logic [WSEL_W:0]   N_EXT = (WSEL_W + 1)'(N);
    localparam logic [WSEL_W-1:0] K_TOP = WSEL_W'(N - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;
    localparam logic [2:0] ST_DRAIN   = 3'd6;

    logic [2:0]                 r_state;
    logic                       r_reg_ack;
    logic                       r_timeout;
    logic [REG_DATA_WIDTH-1:0]  r_rd_data;
    logic                       r_rd_req;
    logic [SRAM_ADDR_WIDTH-1:0] r_rd_addr;
    logic                       r_wr_req;
    logic [SRAM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [SRAM_DATA_WIDTH-1:0] r_wr_data;
    logic [WSEL_W-1:0]          r_wsel;
    logic [REG_DATA_WIDTH-1:0]  r_stage [STG_N];
    logic                       r_latch_vld;
    logic [SRAM_ADDR_WIDTH-1:0] r_tag;
    logic [SRAM_DATA_WIDTH-1:0] r_latch;
    logic [TMO_W-1:0]           r_tmo_cnt;

    logic [SRAM_ADDR_WIDTH-1:0] w_req_addr;
    logic [WSEL_W-1:0]          w_req_wsel;
    logic                       w_req_pad;
    logic                       w_req_top;
    logic                       w_hit;
    logic                       w_tmo_last;
    logic [PAD_W-1:0]           w_rd_pad;
    logic [PAD_W-1:0]           w_latch_pad;
    logic [PAD_W-1:0]           w_wr_vec;
    logic [SRAM_DATA_WIDTH-1:0] w_wr_commit;
    logic [REG_DATA_WIDTH-1:0]  w_rd_words    [WORDS];
    logic [REG_DATA_WIDTH-1:0]  w_latch_words [WORDS];

    assign w_req_addr  = reg_bus.reg_addr[REG_ADDR_WIDTH-1:WSEL_W];
    assign w_req_wsel  = reg_bus.reg_addr[WSEL_W-1:0];
    assign w_req_pad   = {1'b0, w_req_wsel} >= N_EXT;
    assign w_req_top   = w_req_wsel == K_TOP;
    assign w_hit       = r_latch_vld && (r_tag == w_req_addr);
    assign w_tmo_last  = r_tmo_cnt == TMO_W'(TIMEOUT - 1);

    // Zero-extending to a whole number of register words makes the top word
    // right-aligned and the padding words read as zero for free.
    assign w_rd_pad    = PAD_W'(sram_bus.rd_data);
    assign w_latch_pad = PAD_W'(r_latch);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign w_rd_words[gi]    = w_rd_pad[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH];
            assign w_latch_words[gi] = w_latch_pad[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH];
            if (gi < N - 1) begin : g_staged
                assign w_wr_vec[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = r_stage[gi];
            end else if (gi == N - 1) begin : g_top
                assign w_wr_vec[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = reg_bus.reg_wr_data;
            end else begin : g_pad
                assign w_wr_vec[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = '0;
            end
        end
    endgenerate

    assign w_wr_commit = w_wr_vec[SRAM_DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_reg_ack   <= 1'b0;
            r_timeout   <= 1'b0;
            r_rd_data   <= '0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wsel      <= '0;
            r_latch_vld <= 1'b0;
            r_tag       <= '0;
            r_latch     <= '0;
            r_tmo_cnt   <= '0;
            for (int i = 0; i < STG_N; i++) r_stage[i] <= '0;
        end else begin
            r_reg_ack <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: if (reg_bus.reg_req) begin
                    r_wsel <= w_req_wsel;
                    if (w_req_pad) begin
                        r_rd_data <= '0;
                        r_reg_ack <= 1'b1;
                        r_state   <= ST_ACK;
                    end else if (!reg_bus.reg_rd_wr_L) begin
                        if (w_req_top) begin
                            r_wr_addr <= w_req_addr;
                            r_wr_data <= w_wr_commit;
                            r_wr_req  <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            for (int i = 0; i < STG_N; i++)
                                if (w_req_wsel == WSEL_W'(i)) r_stage[i] <= reg_bus.reg_wr_data;
                            r_rd_data <= '0;
                            r_reg_ack <= 1'b1;
                            r_state   <= ST_ACK;
                        end
                    end else if (w_req_wsel != '0 && w_hit) begin
                        r_rd_data <= w_latch_words[w_req_wsel];
                        r_reg_ack <= 1'b1;
                        r_state   <= ST_ACK;
                    end else begin
                        // Word 0 always refetches: it is the software snapshot point.
                        r_rd_addr <= w_req_addr;
                        r_rd_req  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (!reg_bus.reg_req) begin
                        r_rd_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (sram_bus.rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_state  <= ST_RD_WAIT;
                    end else if (w_tmo_last) begin
                        r_rd_req    <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_rd_data   <= '1;
                        r_latch_vld <= 1'b0;
                        r_reg_ack   <= 1'b1;
                        r_state     <= ST_ACK;
                    end
                end
                ST_RD_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (sram_bus.rd_vld) begin
                        r_latch     <= sram_bus.rd_data;
                        r_tag       <= r_rd_addr;
                        r_latch_vld <= 1'b1;
                        if (reg_bus.reg_req) begin
                            r_rd_data <= w_rd_words[r_wsel];
                            r_reg_ack <= 1'b1;
                            r_state   <= ST_ACK;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end else if (!reg_bus.reg_req) begin
                        r_state <= ST_DRAIN;
                    end else if (w_tmo_last) begin
                        r_timeout   <= 1'b1;
                        r_rd_data   <= '1;
                        r_latch_vld <= 1'b0;
                        r_reg_ack   <= 1'b1;
                        r_state     <= ST_ACK;
                    end
                end
                ST_DRAIN: begin
                    // Abandoned read still fills the latch so the data is not wasted.
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (sram_bus.rd_vld) begin
                        r_latch     <= sram_bus.rd_data;
                        r_tag       <= r_rd_addr;
                        r_latch_vld <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_tmo_last) begin
                        r_timeout   <= 1'b1;
                        r_latch_vld <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (!reg_bus.reg_req) begin
                        r_wr_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (sram_bus.wr_ack) begin
                        r_wr_req    <= 1'b0;
                        r_latch     <= r_wr_data;
                        r_tag       <= r_wr_addr;
                        r_latch_vld <= 1'b1;
                        r_rd_data   <= '0;
                        r_reg_ack   <= 1'b1;
                        r_state     <= ST_ACK;
                    end else if (w_tmo_last) begin
                        r_wr_req    <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_latch_vld <= 1'b0;
                        r_rd_data   <= '0;
                        r_reg_ack   <= 1'b1;
                        r_state     <= ST_ACK;
                    end
                end
                ST_ACK:  r_state <= ST_HOLD;
                ST_HOLD: if (!reg_bus.reg_req) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign reg_bus.reg_ack     = r_reg_ack;
    assign reg_bus.reg_rd_data = r_rd_data;
    assign reg_bus.timeout     = r_timeout;
    assign sram_bus.rd_req     = r_rd_req;
    assign sram_bus.rd_addr    = r_rd_addr;
    assign sram_bus.wr_req     = r_wr_req;
    assign sram_bus.wr_addr    = r_wr_addr;
    assign sram_bus.wr_data    = r_wr_data;
endmodule

// File: tb/tb_sram_reg_staged_access.sv
// Bench for sram_reg_staged_access: directed scenarios plus randomized traffic checked
// against a word-level model of the staged bridge and a behavioural SRAM arbiter port.
module tb_sram_reg_staged_access;
    localparam int AW  = 19;
    localparam int DW  = 72;
    localparam int RW  = 32;
    localparam int KW  = 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_reg_bus_if  #(.ADDR_W(AW + KW), .DATA_W(RW)) rbus ();
    sram_arb_port_if #(.ADDR_W(AW), .DATA_W(DW))      sbus ();

    sram_reg_staged_access #(
        .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .REG_DATA_WIDTH(RW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .reg_bus(rbus), .sram_bus(sbus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Initial SRAM contents: a fixed scramble of the address.
    function automatic logic [71:0] init_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'h9E3779B1;
        return {a[7:0], x, ~x ^ 32'h5555AAAA};
    endfunction

    // ---------------- behavioural SRAM arbiter port ----------------
    logic [71:0]   mem [logic [AW-1:0]];
    bit            hold_rd_ack = 0, hold_wr_ack = 0;
    int            ack_dly_max = 0, vld_dly_max = 0, vld_fixed = -1;
    int            rph = 0, rwait = 0, wph = 0, wwait = 0;
    logic [AW-1:0] rd_a;

    initial begin
        sbus.rd_ack = 1'b0; sbus.rd_vld = 1'b0; sbus.wr_ack = 1'b0; sbus.rd_data = '0;
        forever begin
            @(negedge clk);
            sbus.rd_ack = 1'b0; sbus.rd_vld = 1'b0; sbus.wr_ack = 1'b0;
            if (reset) begin
                rph = 0; wph = 0;
            end else begin
                if (rph == 0 && sbus.rd_req && !hold_rd_ack) begin
                    rwait = int'($urandom_range(0, ack_dly_max)); rph = 1;
                end
                if (rph == 1) begin
                    if (!sbus.rd_req) rph = 0;
                    else if (rwait == 0) begin
                        sbus.rd_ack = 1'b1; rd_a = sbus.rd_addr; rph = 2;
                        rwait = (vld_fixed >= 0) ? vld_fixed : int'($urandom_range(0, vld_dly_max));
                    end else rwait--;
                end else if (rph == 2) begin
                    if (rwait == 0) begin
                        sbus.rd_vld  = 1'b1;
                        sbus.rd_data = mem.exists(rd_a) ? mem[rd_a] : init_word(rd_a);
                        rph = 0;
                    end else rwait--;
                end
                if (wph == 0 && sbus.wr_req && !hold_wr_ack) begin
                    wwait = int'($urandom_range(0, ack_dly_max)); wph = 1;
                end
                if (wph == 1) begin
                    if (!sbus.wr_req) wph = 0;
                    else if (wwait == 0) begin
                        sbus.wr_ack = 1'b1; mem[sbus.wr_addr] = sbus.wr_data; wph = 0;
                    end else wwait--;
                end
            end
        end
    end

    // ---------------- passive monitor ----------------
    int            ack_cnt = 0, tmo_cnt = 0, rd_starts = 0, wr_starts = 0;
    logic          prev_rd = 1'b0, prev_wr = 1'b0;
    logic [71:0]   last_wd = '0;
    logic [AW-1:0] last_wa = '0;

    always @(negedge clk) begin
        if (rbus.reg_ack) ack_cnt++;
        if (rbus.timeout) tmo_cnt++;
        if (sbus.rd_req && !prev_rd) rd_starts++;
        if (sbus.wr_req && !prev_wr) wr_starts++;
        if (sbus.wr_req) begin last_wd = sbus.wr_data; last_wa = sbus.wr_addr; end
        prev_rd = sbus.rd_req;
        prev_wr = sbus.wr_req;
    end

    // ---------------- reference model ----------------
    logic [31:0]   m_stage [2];
    bit            m_lvld = 0;
    logic [AW-1:0] m_ltag = '0;
    logic [71:0]   m_ldata = '0;
    logic [71:0]   ref_mem [logic [AW-1:0]];

    function automatic logic [71:0] ref_get(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] word_of(input logic [71:0] v, input int k);
        logic [71:0] s;
        s = v >> (32 * k);
        return s[31:0];
    endfunction

    task automatic drive(input bit rd, input logic [AW-1:0] a, input int k, input logic [31:0] d,
                         output logic [31:0] q, output bit got, output int lat);
        rbus.reg_req = 1'b1; rbus.reg_rd_wr_L = rd;
        rbus.reg_addr = {a, 2'(k)}; rbus.reg_wr_data = d;
        got = 0; lat = 0; q = '0;
        while (!got && lat < 200) begin
            @(posedge clk); #1; lat++;
            if (rbus.reg_ack) begin got = 1; q = rbus.reg_rd_data; end
        end
        rbus.reg_req = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", rbus.reg_ack, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input bit rd, input logic [AW-1:0] a, input int k, input logic [31:0] d);
        int          rs0, ws0, lat;
        logic [31:0] q, exp_q;
        bit          got, exp_rd, exp_wr;
        logic [71:0] exp_wd;
        rs0 = rd_starts; ws0 = wr_starts;
        exp_rd = 0; exp_wr = 0; exp_q = '0; exp_wd = '0;
        if (k >= 3) begin
            exp_q = '0;
        end else if (!rd) begin
            if (k < 2) m_stage[k] = d;
            else begin
                exp_wd = {d[7:0], m_stage[1], m_stage[0]};
                exp_wr = 1; ref_mem[a] = exp_wd;
                m_lvld = 1; m_ltag = a; m_ldata = exp_wd;
            end
        end else if (k > 0 && m_lvld && m_ltag == a) begin
            exp_q = word_of(m_ldata, k);
        end else begin
            exp_rd = 1; m_ldata = ref_get(a); m_ltag = a; m_lvld = 1;
            exp_q = word_of(m_ldata, k);
        end
        drive(rd, a, k, d, q, got, lat);
        check("reg_ack", got, 1);
        if (rd) check("rd_data", q, exp_q);
        check("rd_req_count", rd_starts - rs0, exp_rd);
        check("wr_req_count", wr_starts - ws0, exp_wr);
        if (exp_wr) begin
            check("wr_data", last_wd, exp_wd);
            check("wr_addr", last_wa, a);
        end
        if (!exp_rd && !exp_wr) check("ack_latency", lat, 1);
        $display("txn %s addr=%05h idx=%0d wdata=%08h rdata=%08h lat=%0d",
                 rd ? "RD" : "WR", a, k, d, q, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        bit          got;
        int          lat, t0, a0, ws0;
        logic [AW-1:0] ra;

        rbus.reg_req = 1'b0; rbus.reg_rd_wr_L = 1'b0; rbus.reg_addr = '0; rbus.reg_wr_data = '0;
        m_stage[0] = '0; m_stage[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_ack", rbus.reg_ack, 0);
        check("rst_rd_data", rbus.reg_rd_data, 0);
        check("rst_timeout", rbus.timeout, 0);
        check("rst_rd_req", sbus.rd_req, 0);
        check("rst_wr_req", sbus.wr_req, 0);
        check("rst_wr_data", sbus.wr_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Staged writes, then a single whole-word commit.
        run_txn(0, 19'h100, 0, 32'h11111111);
        run_txn(0, 19'h100, 1, 32'h22222222);
        run_txn(0, 19'h100, 2, 32'h000000AB);
        check("commit_word", last_wd, 72'hAB_22222222_11111111);

        // Latch hit, forced refetch on word 0, miss on another address.
        run_txn(1, 19'h100, 1, 0);
        run_txn(1, 19'h100, 0, 0);
        run_txn(1, 19'h200, 2, 0);

        // Read timeout, then the invalidated latch must miss.
        run_txn(1, 19'h300, 0, 0);
        hold_rd_ack = 1; t0 = tmo_cnt;
        drive(1, 19'h300, 0, 0, q, got, lat);
        check("tmo_rd_ack", got, 1);
        check("tmo_rd_data", q, 32'hFFFFFFFF);
        check("tmo_lat_max17", lat <= 17, 1);
        check("tmo_lat_min16", lat >= TMO, 1);
        check("tmo_pulses", tmo_cnt - t0, 1);
        m_lvld = 0;
        hold_rd_ack = 0;
        run_txn(1, 19'h300, 1, 0);

        // Write timeout: no SRAM update, latch invalidated.
        hold_wr_ack = 1; t0 = tmo_cnt; ws0 = wr_starts;
        drive(0, 19'h500, 2, 32'h5A, q, got, lat);
        check("tmo_wr_ack", got, 1);
        check("tmo_wr_pulses", tmo_cnt - t0, 1);
        check("tmo_wr_req_count", wr_starts - ws0, 1);
        m_lvld = 0;
        hold_wr_ack = 0;
        run_txn(1, 19'h500, 2, 0);

        // Padding word index.
        run_txn(1, 19'h100, 3, 0);
        run_txn(0, 19'h100, 3, 32'hDEADBEEF);

        // Requester walks away after rd_ack: no reg_ack, latch still filled.
        vld_fixed = 5; a0 = ack_cnt;
        rbus.reg_req = 1'b1; rbus.reg_rd_wr_L = 1'b1; rbus.reg_addr = {19'h400, 2'd0};
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            if (sbus.rd_ack) got = 1;
        end
        check("drain_rd_ack_seen", got, 1);
        rbus.reg_req = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("drain_no_reg_ack", ack_cnt - a0, 0);
        vld_fixed = -1;
        m_ldata = ref_get(19'h400); m_ltag = 19'h400; m_lvld = 1;
        run_txn(1, 19'h400, 1, 0);
        run_txn(1, 19'h400, 0, 0);

        // Randomized traffic over a small address pool so the latch gets exercised.
        ack_dly_max = 3; vld_dly_max = 3;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 19'h100;
                1:       ra = 19'h101;
                2:       ra = 19'h200;
                default: ra = 19'($urandom);
            endcase
            run_txn(bit'($urandom_range(0, 1)), ra, int'($urandom_range(0, 3)), $urandom);
        end
        ack_dly_max = 0; vld_dly_max = 0;

        // Reset while a commit is outstanding.
        run_txn(0, 19'h600, 0, 32'h77777777);
        hold_wr_ack = 1;
        rbus.reg_req = 1'b1; rbus.reg_rd_wr_L = 1'b0;
        rbus.reg_addr = {19'h600, 2'd2}; rbus.reg_wr_data = 32'h12;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (sbus.wr_req) got = 1;
        end
        check("rst_mid_wr_req_seen", got, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_wr_req", sbus.wr_req, 0);
        check("rst_mid_reg_ack", rbus.reg_ack, 0);
        rbus.reg_req = 1'b0; hold_wr_ack = 0; reset = 1'b0;
        m_stage[0] = '0; m_stage[1] = '0; m_lvld = 0;
        @(posedge clk); #1;
        run_txn(0, 19'h600, 2, 32'h34);
        run_txn(1, 19'h600, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
